// File: rtl/lfsr_hexgen.sv
// Fibonacci LFSR generator with seed load, single-step and free-run modes,
// period measurement against the last load/reset origin, and registered
// active-low 7-segment encoding of every nibble of the current state.
module lfsr_hexgen #(
  parameter int              WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS  = 'h1D,
  parameter logic [WIDTH-1:0] SEED  = 1,
  parameter int              DIV    = 1,
  localparam int             DIGITS = (WIDTH + 3) / 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  step,
  input  logic                  load,
  input  logic [WIDTH-1:0]      seed_in,
  output logic [WIDTH-1:0]      value,
  output logic                  adv,
  output logic                  zero_fix,
  output logic [WIDTH-1:0]      period,
  output logic                  period_ok,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int              DCW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DCW-1:0]  DIV_LAST = DCW'(DIV - 1);

  // Active-low segments {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic                  step_q;
  logic [DCW-1:0]        div_cnt;
  logic [WIDTH-1:0]      origin_reg;
  logic [WIDTH-1:0]      cnt_reg;

  logic [WIDTH-1:0]      value_next;
  logic [WIDTH-1:0]      origin_next;
  logic [WIDTH-1:0]      cnt_next;
  logic [WIDTH-1:0]      period_next;
  logic                  period_ok_next;
  logic                  adv_next;
  logic                  zero_fix_next;
  logic [DCW-1:0]        div_cnt_next;
  logic [7*DIGITS-1:0]   hex_next;
  logic [4*DIGITS-1:0]   padded_next;

  logic                  tick;
  logic                  adv_req;
  logic                  fb;
  logic [WIDTH-1:0]      lfsr_step;

  assign tick      = (mode == 2'b10) && (div_cnt == DIV_LAST);
  assign adv_req   = ((mode == 2'b01) && step && !step_q) || tick;
  assign fb        = ^(value & TAPS);
  assign lfsr_step = {fb, value[WIDTH-1:1]};

  // Next-state selection: load beats an advance request, otherwise hold.
  always_comb begin
    value_next     = value;
    origin_next    = origin_reg;
    cnt_next       = cnt_reg;
    period_next    = period;
    period_ok_next = period_ok;
    adv_next       = 1'b0;
    zero_fix_next  = 1'b0;
    div_cnt_next   = '0;
    if (mode == 2'b10 && !load)
      div_cnt_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DCW'(1);
    if (load) begin
      value_next     = seed_in;
      origin_next    = seed_in;
      cnt_next       = '0;
      period_ok_next = 1'b0;
    end else if (adv_req) begin
      adv_next = 1'b1;
      if (value == '0) begin
        // Escape the lock-up state; measurement restarts from state 1.
        value_next     = WIDTH'(1);
        zero_fix_next  = 1'b1;
        origin_next    = WIDTH'(1);
        cnt_next       = '0;
        period_ok_next = 1'b0;
      end else begin
        value_next = lfsr_step;
        cnt_next   = cnt_reg + WIDTH'(1);
        if (lfsr_step == origin_reg) begin
          period_next    = cnt_reg + WIDTH'(1);
          period_ok_next = 1'b1;
          cnt_next       = '0;
        end
      end
    end
  end

  // Encode the upcoming value so the display register tracks value with no lag.
  assign padded_next = (4*DIGITS)'(value_next);
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign hex_next[7*gi +: 7] = seg7(padded_next[4*gi +: 4]);
    end
  endgenerate

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value      <= SEED;
      origin_reg <= SEED;
      cnt_reg    <= '0;
      period     <= '0;
      period_ok  <= 1'b0;
      adv        <= 1'b0;
      zero_fix   <= 1'b0;
      step_q     <= 1'b0;
      div_cnt    <= '0;
      hex        <= '0;
      for (int i = 0; i < DIGITS; i++)
        hex[7*i +: 7] <= seg7(((4*DIGITS)'(SEED) >> (4*i)) & (4*DIGITS)'(4'hF));
    end else begin
      value      <= value_next;
      origin_reg <= origin_next;
      cnt_reg    <= cnt_next;
      period     <= period_next;
      period_ok  <= period_ok_next;
      adv        <= adv_next;
      zero_fix   <= zero_fix_next;
      step_q     <= step;
      div_cnt    <= div_cnt_next;
      hex        <= hex_next;
    end
  end

endmodule

// File: tb/tb_lfsr_hexgen.sv
// Directed bench for lfsr_hexgen: one DIV=1 instance and one DIV=3 instance
// sharing stimulus; expected values are hand-computed constants.
module tb_lfsr_hexgen;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        step;
  logic        load;
  logic [7:0]  seed_in;

  logic [7:0]  value,  value3;
  logic        adv,    adv3;
  logic        zero_fix, zero_fix3;
  logic [7:0]  period, period3;
  logic        period_ok, period_ok3;
  logic [13:0] hex,    hex3;

  int asserts = 0;
  int errors  = 0;

  lfsr_hexgen #(.DIV(1)) dut (
    .clk(clk), .rst(rst), .mode(mode), .step(step), .load(load), .seed_in(seed_in),
    .value(value), .adv(adv), .zero_fix(zero_fix), .period(period),
    .period_ok(period_ok), .hex(hex)
  );

  lfsr_hexgen #(.DIV(3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode), .step(step), .load(load), .seed_in(seed_in),
    .value(value3), .adv(adv3), .zero_fix(zero_fix3), .period(period3),
    .period_ok(period_ok3), .hex(hex3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_check;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; mode = 2'b00; step = 1'b0; load = 1'b0; seed_in = 8'h00;
    tick_check();
    tick_check();
    asserts++; if (value !== 8'h01) begin errors++; $display("FAIL reset_value got=%h exp=01", value); end
    asserts++; if (hex !== 14'h2079) begin errors++; $display("FAIL reset_hex got=%h exp=2079", hex); end
    asserts++; if (period_ok !== 1'b0) begin errors++; $display("FAIL reset_period_ok got=%b exp=0", period_ok); end
    asserts++; if (adv !== 1'b0) begin errors++; $display("FAIL reset_adv got=%b exp=0", adv); end
    asserts++; if (period !== 8'h00) begin errors++; $display("FAIL reset_period got=%h exp=00", period); end
    $display("reset: value=%h hex=%h", value, hex);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mode_ignore;
    // Step edge in hold mode is ignored; step_q still tracks it.
    @(negedge clk); mode = 2'b00; step = 1'b1;
    tick_check();
    asserts++; if (value !== 8'h01 || adv !== 1'b0) begin errors++; $display("FAIL hold_ignore value=%h adv=%b exp=01/0", value, adv); end
    // Switching to step mode with step already high must not advance.
    @(negedge clk); mode = 2'b01;
    tick_check();
    asserts++; if (value !== 8'h01 || adv !== 1'b0) begin errors++; $display("FAIL stale_edge value=%h adv=%b exp=01/0", value, adv); end
    $display("mode_ignore: value=%h", value);
    @(negedge clk); step = 1'b0;
    tick_check();
  endtask

  task automatic test_step;
    logic [7:0] exp_seq [5] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
    int pulses;
    mode = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); step = 1'b1;
      tick_check();
      asserts++; if (value !== exp_seq[i]) begin errors++; $display("FAIL step_value[%0d] got=%h exp=%h", i, value, exp_seq[i]); end
      asserts++; if (adv !== 1'b1) begin errors++; $display("FAIL step_adv[%0d] got=%b exp=1", i, adv); end
      @(negedge clk); step = 1'b0;
      tick_check();
      asserts++; if (adv !== 1'b0) begin errors++; $display("FAIL step_adv_low[%0d] got=%b exp=0", i, adv); end
      $display("step %0d: value=%h", i, value);
    end
    // Held high for 10 cycles: exactly one advance, 88 -> C4.
    pulses = 0;
    @(negedge clk); step = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick_check();
      if (adv === 1'b1) pulses++;
    end
    asserts++; if (pulses != 1) begin errors++; $display("FAIL step_held_pulses got=%0d exp=1", pulses); end
    asserts++; if (value !== 8'hC4) begin errors++; $display("FAIL step_held_value got=%h exp=c4", value); end
    $display("step_held: pulses=%0d value=%h", pulses, value);
    @(negedge clk); step = 1'b0;
  endtask

  task automatic test_free_run;
    int adv_count;
    @(negedge clk); rst = 1'b0; mode = 2'b00;
    @(negedge clk); rst = 1'b1; mode = 2'b10;
    adv_count = 0;
    for (int cyc = 1; cyc <= 255; cyc++) begin
      tick_check();
      asserts++; if (adv !== 1'b1) begin errors++; $display("FAIL free_adv_div1 cyc=%0d got=%b exp=1", cyc, adv); end
      if (adv === 1'b1) adv_count++;
      asserts++; if (adv3 !== ((cyc % 3) == 0)) begin errors++; $display("FAIL free_adv_div3 cyc=%0d got=%b exp=%b", cyc, adv3, (cyc % 3) == 0); end
      if (cyc == 254) begin
        asserts++; if (period_ok !== 1'b0) begin errors++; $display("FAIL free_period_ok_early got=%b exp=0", period_ok); end
      end
    end
    asserts++; if (value !== 8'h01) begin errors++; $display("FAIL free_value got=%h exp=01", value); end
    asserts++; if (period !== 8'd255) begin errors++; $display("FAIL free_period got=%0d exp=255", period); end
    asserts++; if (period_ok !== 1'b1) begin errors++; $display("FAIL free_period_ok got=%b exp=1", period_ok); end
    $display("free_run: advances=%0d value=%h period=%0d ok=%b", adv_count, value, period, period_ok);
  endtask

  task automatic test_reset_mid_run;
    for (int c = 0; c < 7; c++) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    asserts++; if (value !== 8'h01) begin errors++; $display("FAIL midrst_value got=%h exp=01", value); end
    asserts++; if (hex !== 14'h2079) begin errors++; $display("FAIL midrst_hex got=%h exp=2079", hex); end
    asserts++; if (period_ok !== 1'b0 || adv !== 1'b0) begin errors++; $display("FAIL midrst_flags ok=%b adv=%b exp=0/0", period_ok, adv); end
    @(negedge clk); rst = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      tick_check();
      asserts++; if (adv3 !== (cyc == 3)) begin errors++; $display("FAIL midrst_div3 cyc=%0d got=%b exp=%b", cyc, adv3, cyc == 3); end
      if (cyc == 1) begin
        asserts++; if (value !== 8'h80) begin errors++; $display("FAIL midrst_resume got=%h exp=80", value); end
      end
    end
    $display("reset_mid_run: value=%h", value);
    @(negedge clk); mode = 2'b00;
  endtask

  task automatic test_load_step;
    @(negedge clk); mode = 2'b01; step = 1'b0;
    tick_check();
    @(negedge clk); load = 1'b1; seed_in = 8'hA5; step = 1'b1;
    tick_check();
    asserts++; if (value !== 8'hA5) begin errors++; $display("FAIL load_value got=%h exp=a5", value); end
    asserts++; if (adv !== 1'b0) begin errors++; $display("FAIL load_adv got=%b exp=0", adv); end
    asserts++; if (period_ok !== 1'b0) begin errors++; $display("FAIL load_period_ok got=%b exp=0", period_ok); end
    asserts++; if (hex !== 14'h0412) begin errors++; $display("FAIL load_hex got=%h exp=0412", hex); end
    @(negedge clk); load = 1'b0;
    tick_check();
    asserts++; if (value !== 8'hA5 || adv !== 1'b0) begin errors++; $display("FAIL load_discard value=%h adv=%b exp=a5/0", value, adv); end
    $display("load_step: value=%h hex=%h", value, hex);
    @(negedge clk); step = 1'b0;
  endtask

  task automatic test_zero_fix;
    @(negedge clk); load = 1'b1; seed_in = 8'h00;
    tick_check();
    asserts++; if (value !== 8'h00) begin errors++; $display("FAIL zero_load got=%h exp=00", value); end
    @(negedge clk); load = 1'b0; step = 1'b1;
    tick_check();
    asserts++; if (value !== 8'h01) begin errors++; $display("FAIL zero_fix_value got=%h exp=01", value); end
    asserts++; if (zero_fix !== 1'b1) begin errors++; $display("FAIL zero_fix_pulse got=%b exp=1", zero_fix); end
    asserts++; if (period_ok !== 1'b0) begin errors++; $display("FAIL zero_fix_period_ok got=%b exp=0", period_ok); end
    asserts++; if (hex !== 14'h2079) begin errors++; $display("FAIL zero_fix_hex got=%h exp=2079", hex); end
    @(negedge clk); step = 1'b0;
    tick_check();
    asserts++; if (zero_fix !== 1'b0 || value !== 8'h01) begin errors++; $display("FAIL zero_fix_end zf=%b value=%h exp=0/01", zero_fix, value); end
    $display("zero_fix: value=%h", value);
  endtask

  initial begin
    test_reset();
    test_mode_ignore();
    test_step();
    test_free_run();
    test_reset_mid_run();
    test_load_step();
    test_zero_fix();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

endmodule
